gen_arb_wrr: RTL and testbench
==============================

# gen_arb_wrr

Parametrised weighted round-robin arbiter with grant locking for the `gen_arbiter` family. Each requester, once it wins, keeps the grant for a programmable number of consecutive accepted beats before priority rotates past it. Within a lock, grants stay with the owner for exactly `wgt+1` acks, or until the owner drops its request. The block sits between N request sources and a shared resource that returns a per-beat `ack`.

## Interface
- `WID`, 16: number of requesters; width of `rqsts` and `grnts`.
- `WGT_W`, 4: width of each per-requester weight field.
- `IDX_W`, `$clog2(WID)`: derived local parameter; width of `grnt_idx`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rqsts`  in  WID  request vector; bit i is requester i.
- `wgts`  in  WID*WGT_W  weights; field i is `wgts[i*WGT_W +: WGT_W]`. Requester i receives `wgt+1` grants per turn.
- `ack`  in  1  the downstream consumed the current grant this cycle. Ignored when `grnt_vld`=0.
- `grnts`  out  WID  one-hot grant; all zeros when no request is present.
- `grnt_vld`  out  1  equals `|rqsts`.
- `grnt_idx`  out  IDX_W  binary index of the granted requester; 0 when `grnt_vld`=0.
- `locked`  out  1  registered; an owner holds remaining credit.

## Operation
- Registered state:
  - `mask[WID]`: thermometer of bits strictly above the last winner.
  - `lock_vld`
  - `owner[IDX_W]`
  - `cnt[WGT_W]`: remaining extra grants.
- Grant selection is combinational from `rqsts` and state:
  - Lock hit, when `lock_vld && rqsts[owner]`: grant `owner`.
  - Otherwise, masked pass: grant the lowest-index set bit of `rqsts & mask`.
  - If the masked pass is empty: grant the lowest-index set bit of `rqsts`. This is the wrap-around case.
- Mask rule: `mask_next[0]=0` and `mask_next[i] = mask_next[i-1] | winner_onehot[i-1]`. A winner at index WID-1 gives an all-zero mask, so priority wraps to index 0.
- Accepted beat (`ack && grnt_vld`), new winner w (not a lock hit):
  - `mask` takes the mask for w.
  - `owner` takes w.
  - `cnt` takes `wgt[w]`.
  - `lock_vld` takes `(wgt[w] != 0)`.
- Accepted beat on a lock hit:
  - `cnt` takes `cnt-1`.
  - If `cnt==1`, `lock_vld` takes 0.
  - `mask` is unchanged, since it already points above `owner`.
- No accepted beat, and `lock_vld && !rqsts[owner]`:
  - `lock_vld` takes 0 and `cnt` takes 0.
  - `owner` and `mask` are unchanged, so the next arbitration starts above the old owner.
- No accepted beat otherwise: all state holds, and `grnts` is stable as long as `rqsts` is stable.
- A weight is sampled only at the first grant of a turn. Weight changes during a lock take effect on the next turn.
- Weight width: `wgt` = max value 2^WGT_W−1, which gives up to 2^WGT_W grants per turn. There is no overflow path, because `cnt` only decrements.
- Requests from non-owners never break a lock. Starvation is bounded by the sum of `(wgt+1)` over the other requesters.

## Timing
- Grant latency is 0 cycles: `grnts`, `grnt_vld` and `grnt_idx` are combinational from `rqsts` and the current state.
- State update latency: an ack at edge k affects the grant from cycle k+1 onward.
- `locked` reflects `lock_vld` and changes one cycle after the causing ack, or after the owner drops its request.
- Reset values: `mask`=0, `lock_vld`=0, `owner`=0, `cnt`=0, so `locked`=0.
  - After reset, the first grant is the lowest-index active request.
  - While `rst_n`=0, `grnts` still follows `rqsts` combinationally under the reset state.
- Reset mid-lock discards the lock and all credit with no residual effect.
- `rqsts`=0 together with `ack`=1: no state change, `grnts`=0.
- Simultaneous owner drop and ack: the combinational grant has already moved to the new winner, so the ack applies to the new winner under the new-winner rule.

## Test plan
- WID=4, all `wgts`=0, `rqsts`=1111, `ack`=1 continuously after reset → `grnts` cycles 0001, 0010, 0100, 1000, 0001; `locked` stays 0.
- WID=4, `wgt[1]`=2, others 0, `rqsts`=1111, `ack`=1 → grants 0001, 0010, 0010, 0010, 0100, 1000; `locked`=1 for exactly the two cycles after the first 0010 grant.
- The scenario above with `ack`=0 for 3 cycles in the middle of the lock → `grnts`, `grnt_idx` and `locked` hold; the remaining grant count is unchanged after `ack` resumes.
- `wgt[2]`=3, `rqsts`=1111 with the mask pointing at 2 → one accepted 0100 grant, then `rqsts[2]` drops → the next grant is 1000 in the same cycle, and `locked` falls on the following edge.
- `rqsts`=1001, all `wgts`=0, `ack`=1 → 0001, 1000, 0001, 1000 (wrap-around); `grnt_idx` alternates 0 and 3.
- Lock active (`locked`=1, `cnt`=2), `rst_n`=0 for one cycle with `rqsts`=0110 → `locked`=0 after the edge, and the next grant is 0010 even if the owner was 2.

Source files
------------

// File: rtl/gen_arb_wrr.sv
// gen_arb_wrr: weighted round-robin arbiter; a winner keeps the grant for wgt+1 accepted beats
//   clk, rst_n (sync, active-low)
//   rqsts    : request vector, bit i = requester i
//   wgts     : per-requester weight fields, wgts[i*WGT_W +: WGT_W]
//   ack      : downstream accepted the current grant
//   grnts    : one-hot grant (combinational), grnt_vld = |rqsts, grnt_idx = binary index
//   locked   : an owner still holds extra grant credit
module gen_arb_wrr #(
  parameter int WID = 16,
  parameter int WGT_W = 4,
  localparam int IDX_W = $clog2(WID)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WID-1:0]       rqsts,
  input  logic [WID*WGT_W-1:0] wgts,
  input  logic                 ack,
  output logic [WID-1:0]       grnts,
  output logic                 grnt_vld,
  output logic [IDX_W-1:0]     grnt_idx,
  output logic                 locked
);
  logic [WID-1:0] mask_q, mask_d, m_req, cand;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [WGT_W-1:0] cnt_q, cnt_d, wgt;
  logic lock_vld_q, lock_vld_d, lock_hit, acc;
  always_comb begin
    lock_hit = lock_vld_q && rqsts[owner_q];
    m_req = rqsts & mask_q;
    cand = lock_hit ? (WID'(1) << owner_q) : (|m_req ? m_req : rqsts);
    // isolate the lowest set bit
    grnts = cand & (~cand + WID'(1));
    grnt_idx = '0;
    for (int i = 0; i < WID; i++) grnt_idx = grnts[i] ? IDX_W'(i) : grnt_idx;
    grnt_vld = |rqsts;
    wgt = wgts[grnt_idx*WGT_W +: WGT_W];
    acc = ack && grnt_vld;
    // bits strictly above the winner; all-zero when the winner is the top index
    mask_d = acc && !lock_hit ? ~(grnts - WID'(1)) & ~grnts : mask_q;
    owner_d = acc && !lock_hit ? grnt_idx : owner_q;
    cnt_d = acc ? (lock_hit ? cnt_q - WGT_W'(1) : wgt) : (lock_hit || !lock_vld_q ? cnt_q : '0);
    // without an accepted beat the lock survives only while the owner keeps requesting
    lock_vld_d = acc ? (lock_hit ? cnt_q != WGT_W'(1) : wgt != '0) : lock_hit;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= '0;
      owner_q <= '0;
      cnt_q <= '0;
      lock_vld_q <= 1'b0;
    end else begin
      mask_q <= mask_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      lock_vld_q <= lock_vld_d;
    end
  end
  assign locked = lock_vld_q;
endmodule

// File: tb/tb_gen_arb_wrr.sv
// tb_gen_arb_wrr: directed-vector bench for gen_arb_wrr at WID=4
module tb_gen_arb_wrr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] rqsts = '0;
  logic [15:0] wgts = '0;
  logic ack = 1'b0;
  logic [3:0] grnts;
  logic grnt_vld;
  logic [1:0] grnt_idx;
  logic locked;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  gen_arb_wrr #(.WID(4), .WGT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rqsts(rqsts), .wgts(wgts), .ack(ack),
    .grnts(grnts), .grnt_vld(grnt_vld), .grnt_idx(grnt_idx), .locked(locked)
  );
  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r = '0;
    for (int j = 0; j < 4; j++) if (g[j]) r = 2'(j);
    return r;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rqsts = '0;
    ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    @(negedge clk);
    rqsts = 4'b0110;
    #1;
    vecs++; if (grnts !== 4'b0010) begin errs++; $display("FAIL reset_follow grnts: got %b want 0010", grnts); end
    vecs++; if (grnt_idx !== 2'd1) begin errs++; $display("FAIL reset_follow idx: got %0d want 1", grnt_idx); end
    vecs++; if (locked !== 1'b0) begin errs++; $display("FAIL reset locked: got %b want 0", locked); end
    rqsts = 4'b0000;
    ack = 1'b1;
    #1;
    vecs++; if (grnts !== 4'b0000) begin errs++; $display("FAIL reset_idle grnts: got %b want 0000", grnts); end
    vecs++; if (grnt_vld !== 1'b0) begin errs++; $display("FAIL reset_idle vld: got %b want 0", grnt_vld); end
    vecs++; if (grnt_idx !== 2'd0) begin errs++; $display("FAIL reset_idle idx: got %0d want 0", grnt_idx); end
    ack = 1'b0;
  endtask
  task automatic test_round_robin();
    logic [3:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    wgts = '0;
    for (int i = 0; i < 5; i++) begin
      rqsts = 4'b1111;
      ack = 1'b1;
      #1;
      vecs++; if (grnts !== eg[i]) begin errs++; $display("FAIL rr grnts step %0d: got %b want %b", i, grnts, eg[i]); end
      vecs++; if (grnt_idx !== idx_of(eg[i])) begin errs++; $display("FAIL rr idx step %0d: got %0d want %0d", i, grnt_idx, idx_of(eg[i])); end
      vecs++; if (locked !== 1'b0) begin errs++; $display("FAIL rr locked step %0d: got %b want 0", i, locked); end
      @(negedge clk);
    end
  endtask
  task automatic test_weight_lock();
    logic [3:0] eg [6] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000};
    logic el [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    wgts = 16'h0020;
    for (int i = 0; i < 6; i++) begin
      rqsts = 4'b1111;
      ack = 1'b1;
      #1;
      vecs++; if (grnts !== eg[i]) begin errs++; $display("FAIL lock grnts step %0d: got %b want %b", i, grnts, eg[i]); end
      vecs++; if (locked !== el[i]) begin errs++; $display("FAIL lock locked step %0d: got %b want %b", i, locked, el[i]); end
      @(negedge clk);
    end
  endtask
  task automatic test_ack_stall();
    logic ea [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] eg [9] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000};
    logic el [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    wgts = 16'h0020;
    for (int i = 0; i < 9; i++) begin
      rqsts = 4'b1111;
      ack = ea[i];
      #1;
      vecs++; if (grnts !== eg[i]) begin errs++; $display("FAIL stall grnts step %0d: got %b want %b", i, grnts, eg[i]); end
      vecs++; if (grnt_idx !== idx_of(eg[i])) begin errs++; $display("FAIL stall idx step %0d: got %0d want %0d", i, grnt_idx, idx_of(eg[i])); end
      vecs++; if (locked !== el[i]) begin errs++; $display("FAIL stall locked step %0d: got %b want %b", i, locked, el[i]); end
      @(negedge clk);
    end
  endtask
  task automatic test_owner_drop();
    do_reset();
    wgts = 16'h0300;
    rqsts = 4'b1111;
    ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    vecs++; if (grnts !== 4'b0100) begin errs++; $display("FAIL drop first grnts: got %b want 0100", grnts); end
    @(negedge clk);
    #1;
    vecs++; if (locked !== 1'b1) begin errs++; $display("FAIL drop locked_on: got %b want 1", locked); end
    rqsts = 4'b1011;
    ack = 1'b0;
    #1;
    vecs++; if (grnts !== 4'b1000) begin errs++; $display("FAIL drop same_cycle grnts: got %b want 1000", grnts); end
    vecs++; if (locked !== 1'b1) begin errs++; $display("FAIL drop locked_hold: got %b want 1", locked); end
    @(negedge clk);
    #1;
    vecs++; if (locked !== 1'b0) begin errs++; $display("FAIL drop locked_off: got %b want 0", locked); end
    vecs++; if (grnts !== 4'b1000) begin errs++; $display("FAIL drop after grnts: got %b want 1000", grnts); end
    ack = 1'b1;
    @(negedge clk);
    #1;
    vecs++; if (grnts !== 4'b0001) begin errs++; $display("FAIL drop wrap grnts: got %b want 0001", grnts); end
    vecs++; if (locked !== 1'b0) begin errs++; $display("FAIL drop wrap locked: got %b want 0", locked); end
  endtask
  task automatic test_wrap_idle();
    logic [3:0] er [5] = '{4'b1001, 4'b0000, 4'b1001, 4'b1001, 4'b1001};
    logic [3:0] eg [5] = '{4'b0001, 4'b0000, 4'b1000, 4'b0001, 4'b1000};
    do_reset();
    wgts = '0;
    for (int i = 0; i < 5; i++) begin
      rqsts = er[i];
      ack = 1'b1;
      #1;
      vecs++; if (grnts !== eg[i]) begin errs++; $display("FAIL wrap grnts step %0d: got %b want %b", i, grnts, eg[i]); end
      vecs++; if (grnt_idx !== idx_of(eg[i])) begin errs++; $display("FAIL wrap idx step %0d: got %0d want %0d", i, grnt_idx, idx_of(eg[i])); end
      vecs++; if (grnt_vld !== (er[i] != 4'b0000)) begin errs++; $display("FAIL wrap vld step %0d: got %b want %b", i, grnt_vld, er[i] != 4'b0000); end
      @(negedge clk);
    end
  endtask
  task automatic test_reset_mid_lock();
    do_reset();
    wgts = 16'h0200;
    rqsts = 4'b1111;
    ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    vecs++; if (locked !== 1'b1) begin errs++; $display("FAIL midrst locked_on: got %b want 1", locked); end
    vecs++; if (grnts !== 4'b0100) begin errs++; $display("FAIL midrst lock_grnt: got %b want 0100", grnts); end
    rst_n = 1'b0;
    rqsts = 4'b0110;
    ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vecs++; if (locked !== 1'b0) begin errs++; $display("FAIL midrst locked_off: got %b want 0", locked); end
    vecs++; if (grnts !== 4'b0010) begin errs++; $display("FAIL midrst grnts: got %b want 0010", grnts); end
    vecs++; if (grnt_idx !== 2'd1) begin errs++; $display("FAIL midrst idx: got %0d want 1", grnt_idx); end
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_weight_lock();
    test_ack_stall();
    test_owner_drop();
    test_wrap_idle();
    test_reset_mid_lock();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
